// File: rtl/prog_clock_divider_if.sv
// Control and status bundle for prog_clock_divider: per-channel enables,
// phase sync, divisor write port and the divided outputs.
interface prog_clock_divider_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int SELW     = 4
);
  logic [CHANNELS-1:0] en;
  logic                sync;
  logic                div_load;
  logic [SELW-1:0]     div_sel;
  logic [WIDTH-1:0]    div_value;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;

  modport master (
    output en, sync, div_load, div_sel, div_value,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, sync, div_load, div_sel, div_value,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider: per-channel 50% duty
// square waves plus rising-edge tick strobes, divisors reloaded at half-period boundaries.
module prog_clock_divider #(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 32'd50000000,
  parameter int          SELW        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  prog_clock_divider_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_HALF = WIDTH'(DEFAULT_DIV);

  logic [CHANNELS-1:0] w_clk_out;
  logic [CHANNELS-1:0] w_tick;
  logic [CHANNELS-1:0] w_pending;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [SELW-1:0] CH_IDX = SELW'(i);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_half;
    logic [WIDTH-1:0] r_nxt;
    logic             r_clk;
    logic             r_tick;
    logic             r_pending;
    logic             w_bnd;
    logic             w_load;
    logic [WIDTH-1:0] w_val;

    // Boundary detect and divisor write decode; a zero divisor is stored as 1.
    always_comb begin
      w_bnd  = 1'b0;
      w_load = 1'b0;
      w_val  = bus.div_value;
      if (r_cnt == (r_half - WIDTH'(1))) begin
        w_bnd = 1'b1;
      end else begin
        w_bnd = 1'b0;
      end
      if (bus.div_load && (bus.div_sel == CH_IDX)) begin
        w_load = 1'b1;
      end else begin
        w_load = 1'b0;
      end
      if (bus.div_value == {WIDTH{1'b0}}) begin
        w_val = WIDTH'(1);
      end else begin
        w_val = bus.div_value;
      end
    end

    // Channel counter, output phase, tick strobe and divisor staging.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt     <= {WIDTH{1'b0}};
        r_half    <= RST_HALF;
        r_nxt     <= RST_HALF;
        r_clk     <= 1'b0;
        r_tick    <= 1'b0;
        r_pending <= 1'b0;
      end else if (bus.sync) begin
        // Sync realigns phase and applies any staged divisor, even one written now.
        r_cnt     <= {WIDTH{1'b0}};
        r_clk     <= 1'b0;
        r_tick    <= 1'b0;
        r_pending <= 1'b0;
        if (w_load) begin
          r_half <= w_val;
          r_nxt  <= w_val;
        end else if (r_pending) begin
          r_half <= r_nxt;
        end
      end else begin
        r_tick <= 1'b0;
        if (bus.en[i]) begin
          if (w_bnd) begin
            r_cnt  <= {WIDTH{1'b0}};
            r_clk  <= ~r_clk;
            r_tick <= ~r_clk;
            if (r_pending) begin
              r_half <= r_nxt;
            end
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
        // A write landing on a boundary stays staged for the following boundary.
        if (w_load) begin
          r_nxt     <= w_val;
          r_pending <= 1'b1;
        end else if (bus.en[i] && w_bnd && r_pending) begin
          r_pending <= 1'b0;
        end
      end
    end

    assign w_clk_out[i] = r_clk;
    assign w_tick[i]    = r_tick;
    assign w_pending[i] = r_pending;
  end

  assign bus.clk_out = w_clk_out;
  assign bus.tick    = w_tick;
  assign bus.pending = w_pending;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed testbench for prog_clock_divider with DEFAULT_DIV=3 and 4 channels;
// expected waveforms are hand-derived edge by edge from reset release.
module tb_prog_clock_divider;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  prog_clock_divider_if #(.CHANNELS(4), .WIDTH(32), .SELW(4)) u_if ();

  prog_clock_divider #(
    .CHANNELS(4), .WIDTH(32), .DEFAULT_DIV(32'd3), .SELW(4)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    u_if.en = 4'b0000;
    u_if.sync = 1'b0;
    u_if.div_load = 1'b0;
    u_if.div_sel = 4'd0;
    u_if.div_value = 32'd0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic load(input logic [3:0] sel, input logic [31:0] val);
    u_if.div_load = 1'b1;
    u_if.div_sel = sel;
    u_if.div_value = val;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (u_if.clk_out !== 4'b0000) begin n_errors++; $display("FAIL reset_clk_out got %b exp 0000", u_if.clk_out); end
    n_checks++; if (u_if.tick !== 4'b0000) begin n_errors++; $display("FAIL reset_tick got %b exp 0000", u_if.tick); end
    n_checks++; if (u_if.pending !== 4'b0000) begin n_errors++; $display("FAIL reset_pending got %b exp 0000", u_if.pending); end
  endtask

  task automatic test_basic();
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    do_reset();
    u_if.en = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      step();
      e_clk  = (((k / 3) % 2) == 1) ? 4'b1111 : 4'b0000;
      e_tick = ((k % 6) == 3) ? 4'b1111 : 4'b0000;
      n_checks++; if (u_if.clk_out !== e_clk) begin n_errors++; $display("FAIL basic_clk edge %0d got %b exp %b", k, u_if.clk_out, e_clk); end
      n_checks++; if (u_if.tick !== e_tick) begin n_errors++; $display("FAIL basic_tick edge %0d got %b exp %b", k, u_if.tick, e_tick); end
    end
  endtask

  task automatic test_load();
    do_reset();
    u_if.en = 4'b1111;
    step();
    load(4'd1, 32'd5);
    step();
    u_if.div_load = 1'b0;
    n_checks++; if (u_if.pending !== 4'b0010) begin n_errors++; $display("FAIL load_pending e2 got %b exp 0010", u_if.pending); end
    step();
    n_checks++; if (u_if.pending !== 4'b0000) begin n_errors++; $display("FAIL load_pending e3 got %b exp 0000", u_if.pending); end
    n_checks++; if (u_if.clk_out[1] !== 1'b1 || u_if.tick[1] !== 1'b1) begin n_errors++; $display("FAIL load_rise e3 got clk %b tick %b exp 1 1", u_if.clk_out[1], u_if.tick[1]); end
    repeat (4) step();
    n_checks++; if (u_if.clk_out[1] !== 1'b1) begin n_errors++; $display("FAIL load_hold e7 got %b exp 1", u_if.clk_out[1]); end
    step();
    n_checks++; if (u_if.clk_out[1] !== 1'b0) begin n_errors++; $display("FAIL load_fall e8 got %b exp 0", u_if.clk_out[1]); end
    repeat (4) step();
    n_checks++; if (u_if.clk_out[1] !== 1'b0) begin n_errors++; $display("FAIL load_low e12 got %b exp 0", u_if.clk_out[1]); end
    step();
    n_checks++; if (u_if.clk_out[1] !== 1'b1 || u_if.tick[1] !== 1'b1) begin n_errors++; $display("FAIL load_rise e13 got clk %b tick %b exp 1 1", u_if.clk_out[1], u_if.tick[1]); end
  endtask

  task automatic test_back_to_back();
    logic e_clk;
    do_reset();
    u_if.en = 4'b1111;
    load(4'd0, 32'd9);
    step();
    n_checks++; if (u_if.pending !== 4'b0001) begin n_errors++; $display("FAIL b2b_pending e1 got %b exp 0001", u_if.pending); end
    load(4'd0, 32'd5);
    step();
    load(4'd0, 32'd2);
    step();
    u_if.div_load = 1'b0;
    n_checks++; if (u_if.pending !== 4'b0001) begin n_errors++; $display("FAIL b2b_pending e3 got %b exp 0001", u_if.pending); end
    n_checks++; if (u_if.clk_out[0] !== 1'b1 || u_if.tick[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_rise e3 got clk %b tick %b exp 1 1", u_if.clk_out[0], u_if.tick[0]); end
    for (int k = 4; k <= 12; k++) begin
      step();
      e_clk = (k <= 7) || (k == 10) || (k == 11);
      n_checks++; if (u_if.clk_out[0] !== e_clk) begin n_errors++; $display("FAIL b2b_clk edge %0d got %b exp %b", k, u_if.clk_out[0], e_clk); end
      n_checks++; if (u_if.pending[0] !== (k <= 7)) begin n_errors++; $display("FAIL b2b_pending edge %0d got %b exp %b", k, u_if.pending[0], (k <= 7)); end
      n_checks++; if (u_if.tick[0] !== (k == 10)) begin n_errors++; $display("FAIL b2b_tick edge %0d got %b exp %b", k, u_if.tick[0], (k == 10)); end
    end
  endtask

  task automatic test_zero_badsel();
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    do_reset();
    u_if.en = 4'b1111;
    load(4'd2, 32'd0);
    step();
    load(4'd7, 32'd1);
    step();
    u_if.div_load = 1'b0;
    n_checks++; if (u_if.pending !== 4'b0100) begin n_errors++; $display("FAIL zero_pending e2 got %b exp 0100", u_if.pending); end
    step();
    n_checks++; if (u_if.clk_out !== 4'b1111 || u_if.pending !== 4'b0000) begin n_errors++; $display("FAIL zero_e3 got clk %b pend %b exp 1111 0000", u_if.clk_out, u_if.pending); end
    for (int k = 4; k <= 9; k++) begin
      step();
      e_clk     = (((k / 3) % 2) == 1) ? 4'b1011 : 4'b0000;
      e_clk[2]  = ((k % 2) == 1);
      e_tick    = ((k % 6) == 3) ? 4'b1011 : 4'b0000;
      e_tick[2] = ((k % 2) == 1);
      n_checks++; if (u_if.clk_out !== e_clk) begin n_errors++; $display("FAIL zero_clk edge %0d got %b exp %b", k, u_if.clk_out, e_clk); end
      n_checks++; if (u_if.tick !== e_tick) begin n_errors++; $display("FAIL zero_tick edge %0d got %b exp %b", k, u_if.tick, e_tick); end
    end
  endtask

  task automatic test_enable();
    logic [2:0] e_hi;
    do_reset();
    u_if.en = 4'b1111;
    step();
    step();
    u_if.en = 4'b1110;
    for (int k = 3; k <= 12; k++) begin
      if (k == 5) load(4'd0, 32'd2);
      step();
      u_if.div_load = 1'b0;
      e_hi = (((k / 3) % 2) == 1) ? 3'b111 : 3'b000;
      n_checks++; if (u_if.clk_out[0] !== 1'b0 || u_if.tick[0] !== 1'b0) begin n_errors++; $display("FAIL en_freeze edge %0d got clk %b tick %b exp 0 0", k, u_if.clk_out[0], u_if.tick[0]); end
      n_checks++; if (u_if.clk_out[3:1] !== e_hi) begin n_errors++; $display("FAIL en_others edge %0d got %b exp %b", k, u_if.clk_out[3:1], e_hi); end
    end
    n_checks++; if (u_if.pending[0] !== 1'b1) begin n_errors++; $display("FAIL en_pending e12 got %b exp 1", u_if.pending[0]); end
    u_if.en = 4'b1111;
    step();
    n_checks++; if (u_if.clk_out[0] !== 1'b1 || u_if.tick[0] !== 1'b1 || u_if.pending[0] !== 1'b0) begin n_errors++; $display("FAIL en_resume e13 got clk %b tick %b pend %b exp 1 1 0", u_if.clk_out[0], u_if.tick[0], u_if.pending[0]); end
    step();
    n_checks++; if (u_if.clk_out[0] !== 1'b1 || u_if.tick[0] !== 1'b0) begin n_errors++; $display("FAIL en_e14 got clk %b tick %b exp 1 0", u_if.clk_out[0], u_if.tick[0]); end
    step();
    n_checks++; if (u_if.clk_out[0] !== 1'b0) begin n_errors++; $display("FAIL en_fall e15 got %b exp 0", u_if.clk_out[0]); end
    step();
    step();
    n_checks++; if (u_if.clk_out[0] !== 1'b1 || u_if.tick[0] !== 1'b1) begin n_errors++; $display("FAIL en_rise e17 got clk %b tick %b exp 1 1", u_if.clk_out[0], u_if.tick[0]); end
  endtask

  task automatic test_sync();
    logic [3:0] e_clk  [7];
    logic [3:0] e_tick [7];
    e_clk  = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b0110, 4'b0101, 4'b1101};
    e_tick = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b1000};
    do_reset();
    load(4'd0, 32'd2);
    step();
    load(4'd2, 32'd4);
    step();
    load(4'd3, 32'd5);
    step();
    u_if.div_load = 1'b0;
    n_checks++; if (u_if.pending !== 4'b1101 || u_if.clk_out !== 4'b0000) begin n_errors++; $display("FAIL sync_stage e3 got pend %b clk %b exp 1101 0000", u_if.pending, u_if.clk_out); end
    u_if.sync = 1'b1;
    step();
    u_if.sync = 1'b0;
    n_checks++; if (u_if.pending !== 4'b0000) begin n_errors++; $display("FAIL sync_apply e4 got %b exp 0000", u_if.pending); end
    u_if.en = 4'b1111;
    step();
    step();
    n_checks++; if (u_if.clk_out !== 4'b0001 || u_if.tick !== 4'b0001) begin n_errors++; $display("FAIL sync_run e6 got clk %b tick %b exp 0001 0001", u_if.clk_out, u_if.tick); end
    repeat (5) step();
    u_if.sync = 1'b1;
    load(4'd3, 32'd7);
    step();
    u_if.sync = 1'b0;
    u_if.div_load = 1'b0;
    n_checks++; if (u_if.clk_out !== 4'b0000 || u_if.tick !== 4'b0000 || u_if.pending !== 4'b0000) begin n_errors++; $display("FAIL sync_clear e12 got clk %b tick %b pend %b exp 0000 0000 0000", u_if.clk_out, u_if.tick, u_if.pending); end
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++; if (u_if.clk_out !== e_clk[k]) begin n_errors++; $display("FAIL sync_clk edge %0d got %b exp %b", k + 13, u_if.clk_out, e_clk[k]); end
      n_checks++; if (u_if.tick !== e_tick[k]) begin n_errors++; $display("FAIL sync_tick edge %0d got %b exp %b", k + 13, u_if.tick, e_tick[k]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    u_if.en = 4'b1111;
    step();
    step();
    load(4'd1, 32'd6);
    step();
    u_if.div_load = 1'b0;
    n_checks++; if (u_if.clk_out !== 4'b1111 || u_if.tick !== 4'b1111 || u_if.pending !== 4'b0010) begin n_errors++; $display("FAIL arst_pre got clk %b tick %b pend %b exp 1111 1111 0010", u_if.clk_out, u_if.tick, u_if.pending); end
    reset = 1'b0;
    #1;
    n_checks++; if (u_if.clk_out !== 4'b0000 || u_if.tick !== 4'b0000 || u_if.pending !== 4'b0000) begin n_errors++; $display("FAIL arst_async got clk %b tick %b pend %b exp 0000 0000 0000", u_if.clk_out, u_if.tick, u_if.pending); end
    step();
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) begin
        n_checks++; if (u_if.clk_out !== 4'b1111) begin n_errors++; $display("FAIL arst_default_rise e3 got %b exp 1111", u_if.clk_out); end
      end else if (k == 6) begin
        n_checks++; if (u_if.clk_out !== 4'b0000) begin n_errors++; $display("FAIL arst_default_fall e6 got %b exp 0000", u_if.clk_out); end
      end else begin
        n_checks++; if (u_if.pending !== 4'b0000) begin n_errors++; $display("FAIL arst_pending edge %0d got %b exp 0000", k, u_if.pending); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_load();
    test_back_to_back();
    test_zero_badsel();
    test_enable();
    test_sync();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
